// File: rtl/instr_seq_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcodes,
// datapath select values and branch condition codes.
package instr_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_HALT    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic [3:0] OP_IMM  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BR   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JSR  = 4'hD;
  localparam logic [3:0] OP_RTS  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] FS_IMM = 4'h2;
  localparam logic [1:0] MB_REG = 2'b00;
  localparam logic [1:0] MB_IMM = 2'b01;

  localparam logic [1:0] CC_Z = 2'd0;
  localparam logic [1:0] CC_N = 2'd1;
  localparam logic [1:0] CC_C = 2'd2;
  localparam logic [1:0] CC_V = 2'd3;

  function automatic logic cc_flag(input logic [1:0] cc, input logic v, input logic c,
                                   input logic n, input logic z);
    logic f;
    case (cc)
      CC_Z:    f = z;
      CC_N:    f = n;
      CC_C:    f = c;
      CC_V:    f = v;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for JSR/RTS; only exists when INSTR_SEQ_STACK_EN is defined.
`ifdef INSTR_SEQ_STACK_EN
module ret_stack
  import instr_seq_pkg::*;
#(
  parameter int PC_W        = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0]  mem_r [STACK_DEPTH];
  logic [SP_W-1:0]  sp_r;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign full     = (sp_r == SP_W'(STACK_DEPTH));
  assign empty    = (sp_r == '0);
  assign wr_idx_s = IDX_W'(sp_r);
  assign rd_idx_s = IDX_W'(sp_r - SP_W'(1'b1));
  assign top      = empty ? '0 : mem_r[rd_idx_s];

  // Overflowing pushes and underflowing pops are ignored; the sequencer flags them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_r <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_r[i] <= '0;
    end else if (push && !full) begin
      mem_r[wr_idx_s] <= push_data;
      sp_r            <= sp_r + SP_W'(1'b1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - SP_W'(1'b1);
    end else begin
      sp_r <= sp_r;
    end
  end

endmodule
`endif

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer driving datapath controls from a 16-bit instruction.
// Define INSTR_SEQ_STACK_EN to enable JSR/RTS with a return stack.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              rom_req,
  output logic [PC_W-1:0]   pc,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  input  logic              V,
  input  logic              C,
  input  logic              N,
  input  logic              Z,
  input  logic [DATA_W-1:0] bus_a,
  input  logic              mem_ready,
  output logic [3:0]        DR,
  output logic [3:0]        SA,
  output logic [3:0]        SB,
  output logic [3:0]        FS,
  output logic [1:0]        MB,
  output logic              MD,
  output logic              RW,
  output logic              MW,
  output logic [DATA_W-1:0] imdt,
  output logic              halted,
  output logic              stack_err,
  output logic [1:0]        state
);

  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s, pc_inc_s, br_off_s;
  logic [15:0]     ir_r, ir_s;
  logic [3:0]      op_s;
  logic            unused_bus_bits;

`ifdef INSTR_SEQ_STACK_EN
  logic            err_r, err_s;
  logic            push_s, pop_s;
  logic            stk_full_s, stk_empty_s;
  logic [PC_W-1:0] stk_top_s;
`endif

  assign op_s            = ir_r[15:12];
  assign pc_inc_s        = pc_r + PC_W'(1'b1);
  assign br_off_s        = PC_W'($signed(ir_r[7:0]));
  assign unused_bus_bits = ^bus_a;

  // Architectural state: FSM, program counter, instruction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_FETCH;
      pc_r    <= '0;
      ir_r    <= '0;
`ifdef INSTR_SEQ_STACK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
`ifdef INSTR_SEQ_STACK_EN
      err_r   <= err_s;
`endif
    end
  end

  // Next-state, next-pc and datapath control decode.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    FS      = 4'h0;
    MB      = MB_REG;
    MD      = 1'b0;
    RW      = 1'b0;
    MW      = 1'b0;
`ifdef INSTR_SEQ_STACK_EN
    err_s   = err_r;
    push_s  = 1'b0;
    pop_s   = 1'b0;
`endif
    case (state_r)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_s    = instr;
          state_s = ST_EXEC;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        state_s = ST_FETCH;
        pc_s    = pc_inc_s;
        case (op_s)
          OP_IMM: begin
            FS = FS_IMM;
            MB = MB_IMM;
            RW = 1'b1;
          end
          // Memory ops stall in EXEC; the write strobe fires only on completion.
          OP_LD: begin
            MD = 1'b1;
            if (mem_ready) begin
              RW = 1'b1;
            end else begin
              state_s = ST_EXEC;
              pc_s    = pc_r;
            end
          end
          OP_ST: begin
            if (mem_ready) begin
              MW = 1'b1;
            end else begin
              state_s = ST_EXEC;
              pc_s    = pc_r;
            end
          end
          OP_BR: begin
            if (cc_flag(ir_r[9:8], V, C, N, Z)) pc_s = pc_r + br_off_s;
            else                                pc_s = pc_inc_s;
          end
          OP_JMP: pc_s = bus_a[PC_W-1:0];
          OP_JSR: begin
`ifdef INSTR_SEQ_STACK_EN
            if (stk_full_s) begin
              err_s   = 1'b1;
              state_s = ST_HALT;
              pc_s    = pc_r;
            end else begin
              push_s = 1'b1;
              pc_s   = PC_W'(ir_r[7:0]);
            end
`else
            pc_s = pc_inc_s;
`endif
          end
          OP_RTS: begin
`ifdef INSTR_SEQ_STACK_EN
            if (stk_empty_s) begin
              err_s   = 1'b1;
              state_s = ST_HALT;
              pc_s    = pc_r;
            end else begin
              pop_s = 1'b1;
              pc_s  = stk_top_s;
            end
`else
            pc_s = pc_inc_s;
`endif
          end
          OP_HALT: begin
            state_s = ST_HALT;
            pc_s    = pc_r;
          end
          default: begin
            FS = op_s;
            MB = MB_REG;
            RW = 1'b1;
          end
        endcase
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_HALT;
    endcase
  end

`ifdef INSTR_SEQ_STACK_EN
  ret_stack #(
    .PC_W       (PC_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(pc_inc_s),
    .top      (stk_top_s),
    .full     (stk_full_s),
    .empty    (stk_empty_s)
  );
  assign stack_err = err_r;
`else
  assign stack_err = 1'b0;
`endif

  assign rom_req = reset_n & (state_r == ST_FETCH);
  assign pc      = pc_r;
  assign DR      = ir_r[11:8];
  assign SA      = ir_r[7:4];
  assign SB      = ir_r[3:0];
  assign imdt    = DATA_W'(ir_r[7:0]);
  assign halted  = (state_r == ST_HALT);
  assign state   = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised scoreboard bench for instr_sequencer: the driver pushes the
// architecturally expected controls per instruction, a negedge monitor checks them.
module tb_instr_sequencer;

  localparam int DATA_W = 16;
  localparam int PC_W   = 6;
  localparam int DEPTH  = 4;
  localparam int PC_MOD = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rom_req;
  logic [PC_W-1:0]   pc;
  logic              instr_valid;
  logic [15:0]       instr;
  logic              V, C, N, Z;
  logic [DATA_W-1:0] bus_a;
  logic              mem_ready;
  logic [3:0]        DR, SA, SB, FS;
  logic [1:0]        MB;
  logic              MD, RW, MW;
  logic [DATA_W-1:0] imdt;
  logic              halted, stack_err;
  logic [1:0]        state;

  always #5 clk = ~clk;

  instr_sequencer #(.DATA_W(DATA_W), .PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rom_req(rom_req), .pc(pc),
    .instr_valid(instr_valid), .instr(instr),
    .V(V), .C(C), .N(N), .Z(Z), .bus_a(bus_a), .mem_ready(mem_ready),
    .DR(DR), .SA(SA), .SB(SB), .FS(FS), .MB(MB), .MD(MD), .RW(RW), .MW(MW),
    .imdt(imdt), .halted(halted), .stack_err(stack_err), .state(state)
  );

  typedef struct {
    int         pc;
    logic [3:0] dr, sa, sb;
    logic       fs_chk;
    logic [3:0] fs;
    logic [1:0] mb;
    logic       md, rw, mw, mem;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mpc;
  int   mstk[$];
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  function automatic int wrap(input int x);
    return ((x % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  // Architectural reference: expected controls for one instruction, then advance pc.
  task automatic step_model(input logic [15:0] ins, input logic [3:0] vcnz,
                            input logic [15:0] ba, output exp_t e);
    int op, imm, off;
    op  = int'(ins[15:12]);
    imm = int'(ins[7:0]);
    e.pc = mpc; e.dr = ins[11:8]; e.sa = ins[7:4]; e.sb = ins[3:0];
    e.fs_chk = 1'b0; e.fs = 4'h0; e.mb = 2'b00;
    e.md = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.mem = 1'b0;
    if (op <= 7) begin e.fs_chk = 1'b1; e.fs = ins[15:12]; e.rw = 1'b1; end
    else if (op == 8) begin e.fs_chk = 1'b1; e.fs = 4'h2; e.mb = 2'b01; e.rw = 1'b1; end
    else if (op == 9) begin e.md = 1'b1; e.rw = 1'b1; e.mem = 1'b1; end
    else if (op == 10) begin e.mw = 1'b1; e.mem = 1'b1; end
    case (op)
      11: begin
        off = (imm >= 128) ? imm - 256 : imm;
        mpc = vcnz[ins[9:8]] ? wrap(mpc + off) : wrap(mpc + 1);
      end
      12: mpc = int'(ba) % PC_MOD;
`ifdef INSTR_SEQ_STACK_EN
      13: if (mstk.size() < DEPTH) begin mstk.push_back(wrap(mpc + 1)); mpc = imm % PC_MOD; end
      14: if (mstk.size() > 0) mpc = mstk.pop_back();
`endif
      15: mpc = mpc;
      default: mpc = wrap(mpc + 1);
    endcase
  endtask

  task automatic issue(input logic [15:0] ins, input logic [3:0] vcnz, input logic [15:0] ba,
                       input int waits, input int delay);
    exp_t e;
    int guard = 0;
    while (state !== 2'd0) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 20) begin fail_now("fetch_wait"); return; end
    end
    instr_valid = 1'b0;
    repeat (delay) begin @(posedge clk); #1; end
    {V, C, N, Z} = vcnz; bus_a = ba; instr = ins;
    instr_valid = 1'b1;
    mem_ready = (waits == 0);
    step_model(ins, vcnz, ba, e);
    sb_q.push_back(e);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (e.mem) begin
      for (int j = 1; j <= waits; j++) begin @(posedge clk); #1; mem_ready = (j == waits); end
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    sb_q.delete(); mstk.delete(); mpc = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Monitor: check each EXEC cycle against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   done;
    if (reset_n === 1'b1 && mon_en) begin
      if (state == 2'd1) begin
        if (sb_q.size() == 0) begin
          fail_now("exec_without_issue");
        end else begin
          e = sb_q[0];
          chk("exec_pc", 32'(pc), 32'(e.pc));
          chk("ir_fields", 32'({DR, SA, SB}), 32'({e.dr, e.sa, e.sb}));
          chk("imdt", 32'(imdt), 32'({e.sa, e.sb}));
          if (e.fs_chk) chk("fs_mb", 32'({FS, MB}), 32'({e.fs, e.mb}));
          chk("md", 32'(MD), 32'(e.md));
          done = !e.mem || (mem_ready === 1'b1);
          chk("rw", 32'(RW), done ? 32'(e.rw) : 32'd0);
          chk("mw", 32'(MW), done ? 32'(e.mw) : 32'd0);
          if (done) void'(sb_q.pop_front());
        end
      end else begin
        chk("idle_ctrl_zero", 32'({RW, MW, MD, MB}), 32'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; {V, C, N, Z} = 4'h0;
    bus_a = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_outputs", 32'({rom_req, RW, MW, MD, MB, FS, DR, SA, SB, halted, stack_err}), 32'd0);
    chk("reset_imdt", 32'(imdt), 32'd0);
    reset_n = 1'b1; #1;
    chk("rom_req_after_reset", 32'(rom_req), 32'd1);
    mpc = 0; mon_en = 1'b1;

    issue(16'h2123, 4'h0, 16'h0, 0, 0);
    chk("pc_after_alu", 32'(pc), 32'd1);
    issue(16'h9104, 4'h0, 16'h0, 3, 0);
    chk("pc_after_ld", 32'(pc), 32'd2);
    issue(16'hC000, 4'h0, 16'd5, 0, 0);
    issue(16'hB0FE, 4'b0001, 16'h0, 0, 0);
    chk("branch_taken", 32'(pc), 32'd3);
    issue(16'hC000, 4'h0, 16'd5, 0, 0);
    issue(16'hB0FE, 4'b1110, 16'h0, 0, 0);
    chk("branch_not_taken", 32'(pc), 32'd6);
    issue(16'hC000, 4'h0, 16'd63, 0, 0);
    issue(16'hB001, 4'b0001, 16'h0, 0, 0);
    chk("branch_wrap", 32'(pc), 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ins;
      int op, w;
      op = int'($urandom_range(0, 14));
`ifdef INSTR_SEQ_STACK_EN
      if (op == 13 && mstk.size() == DEPTH) op = 0;
      if (op == 14 && mstk.size() == 0) op = 1;
`endif
      ins = 16'($urandom);
      ins[15:12] = 4'(op);
      w = (op == 9 || op == 10) ? int'($urandom_range(0, 3)) : 0;
      issue(ins, 4'($urandom), 16'($urandom), w, int'($urandom_range(0, 2)));
    end
    chk("random_final_pc", 32'(pc), 32'(mpc));
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

`ifdef INSTR_SEQ_STACK_EN
    do_reset();
    issue(16'hD00A, 4'h0, 16'h0, 0, 0);
    issue(16'hD014, 4'h0, 16'h0, 0, 0);
    issue(16'hD01E, 4'h0, 16'h0, 0, 0);
    issue(16'hD028, 4'h0, 16'h0, 0, 0);
    chk("jsr_depth4_pc", 32'(pc), 32'd40);
    issue(16'hE000, 4'h0, 16'h0, 0, 0); chk("rts1", 32'(pc), 32'd31);
    issue(16'hE000, 4'h0, 16'h0, 0, 0); chk("rts2", 32'(pc), 32'd21);
    issue(16'hE000, 4'h0, 16'h0, 0, 0); chk("rts3", 32'(pc), 32'd11);
    issue(16'hE000, 4'h0, 16'h0, 0, 0); chk("rts4", 32'(pc), 32'd1);
    chk("no_stack_err_yet", 32'(stack_err), 32'd0);
    for (int k = 0; k < 5; k++) issue(16'hD000 | 16'(k + 2), 4'h0, 16'h0, 0, 0);
    chk("overflow_stack_err", 32'(stack_err), 32'd1);
    chk("overflow_halted", 32'(halted), 32'd1);
`else
    issue(16'hD00A, 4'h0, 16'h0, 0, 0);
    chk("jsr_is_nop", 32'(pc), 32'(mpc));
    issue(16'hE000, 4'h0, 16'h0, 0, 0);
    chk("rts_is_nop", 32'(pc), 32'(mpc));
    chk("stack_err_tied", 32'(stack_err), 32'd0);
`endif

    // Reset in the middle of a stalled store.
    do_reset();
    issue(16'hC000, 4'h0, 16'd17, 0, 0);
    chk("pc_before_st", 32'(pc), 32'd17);
    instr = 16'hA123; mem_ready = 1'b0; instr_valid = 1'b1;
    begin
      exp_t e;
      step_model(16'hA123, 4'h0, 16'h0, e);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_st_state", 32'(state), 32'd0);
    chk("rst_mid_st_pc", 32'(pc), 32'd0);
    chk("rst_mid_st_mw", 32'(MW), 32'd0);
    sb_q.delete(); mstk.delete(); mpc = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    issue(16'h5321, 4'h0, 16'h0, 0, 0);
    issue(16'hF000, 4'h0, 16'h0, 0, 0);
    chk("halt_halted", 32'(halted), 32'd1);
    instr = 16'h2123; instr_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    instr_valid = 1'b0;
    chk("halt_sticky_state", 32'(state), 32'd2);
    chk("halt_sticky_halted", 32'(halted), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: datapath and bus_a width.
REQ-002 The block SHALL have parameter PC_W, default 6: program counter width.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4: return-stack entries, minimum 2.
REQ-004 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have ports rom_req (output, 1) and pc (output, PC_W): instruction fetch request and address.
REQ-007 The block SHALL have ports instr_valid (input, 1) and instr (input, 16): fetch acknowledge and data.
REQ-008 The block SHALL have ports V, C, N, Z (inputs, 1 each): ALU flags.
REQ-009 The block SHALL have port bus_a, input, DATA_W: register-file A bus, used as the jump target.
REQ-010 The block SHALL have port mem_ready, input, 1: data-RAM access done.
REQ-011 The block SHALL have outputs DR, SA, SB, FS (4 bits each), MB (2 bits), MD, RW, MW (1 bit each): datapath controls.
REQ-012 The block SHALL have output imdt, DATA_W bits: zero-extended {SA,SB}.
REQ-013 The block SHALL have outputs halted (1 bit), stack_err (1 bit) and state (2 bits).

Function
REQ-014 The instruction fields SHALL be: opcode instr[15:12], DR [11:8], SA [7:4], SB [3:0], all latched in the IR on the instr_valid cycle.
REQ-015 The FSM SHALL have states FETCH=0, EXEC=1 and HALT=2; encoding 3 SHALL go to HALT.
REQ-016 In FETCH, rom_req SHALL be 1; instr_valid=1 SHALL latch the IR and move to EXEC, otherwise the FSM SHALL hold.
REQ-017 Opcodes 0x0-0x7 SHALL drive FS=opcode, MB=00 and RW=1 for one EXEC cycle, then set pc=pc+1.
REQ-018 Opcode 0x8 SHALL behave as an ALU op with FS=0x2 and MB=01 (immediate).
REQ-019 Opcode 0x9 (LD) SHALL drive MD=1 and hold EXEC until mem_ready=1; RW=1 SHALL be asserted only in the mem_ready cycle.
REQ-020 Opcode 0xA (ST) SHALL hold EXEC until mem_ready=1, with MW=1 asserted only in that cycle.
REQ-021 Opcode 0xB (branch) SHALL select its flag by DR[1:0] (00 Z, 01 N, 10 C, 11 V); if the flag is 1, pc SHALL become pc + sign-extended {SA,SB}, else pc+1.
REQ-022 Opcode 0xC (jump) SHALL set pc=bus_a[PC_W-1:0].
REQ-023 Opcode 0xF SHALL enter HALT with halted=1; HALT SHALL be left only by reset.
REQ-024 All pc arithmetic SHALL wrap modulo 2^PC_W.
REQ-025 RW, MW, MD and MB SHALL be 0 outside EXEC.
REQ-026 An ALU or branch instruction SHALL complete in 2 cycles with zero-wait ROM.

Reset
REQ-027 While reset_n=0, state SHALL be FETCH, pc=0, IR=0, stack pointer=0, and all outputs 0 except rom_req=1 after release.
REQ-028 Reset asserted mid-LD/ST SHALL abort the access immediately, with no RW or MW pulse.

Configuration
REQ-029 With INSTR_SEQ_STACK_EN defined, opcode 0xD (JSR) SHALL push pc+1 and set pc={SA,SB}[PC_W-1:0], and opcode 0xE (RTS) SHALL pop into pc.
REQ-030 With INSTR_SEQ_STACK_EN defined, a push when full or a pop when empty SHALL set stack_err=1 and enter HALT, leaving the stack unchanged.
REQ-031 Without INSTR_SEQ_STACK_EN, opcodes 0xD/0xE SHALL be NOPs (pc+1), no stack storage SHALL exist, and stack_err SHALL be tied to 0.

Structure
REQ-032 Opcode localparams, state encoding and condition-code constants SHALL live in package instr_seq_pkg.
REQ-033 The return stack SHALL be a sub-module ret_stack (parameters PC_W and STACK_DEPTH), instantiated only under INSTR_SEQ_STACK_EN.

Verification
REQ-034 Reset, then instr=0x2123 with instr_valid=1 -> the next cycle shows FS=2, RW=1, DR=1, SA=2, SB=3, and pc=1 afterwards.
REQ-035 LD (0x9104) with mem_ready low for 3 cycles -> MD=1 throughout, RW=1 only in the 4th EXEC cycle, pc advances once.
REQ-036 At pc=5, Z=1, instr=0xB0FE -> pc=3; with Z=0 -> pc=6; branch at pc=63 with offset +1 -> pc=0.
REQ-037 With the stack enabled, 5 nested JSRs with STACK_DEPTH=4 -> the 5th sets stack_err=1 and halted=1; 4 JSR then 4 RTS return the correct addresses.
REQ-038 reset_n pulsed low mid-ST while mem_ready=0 -> MW is never 1, and pc=0 with state=FETCH immediately.
